vfifo_mq_ctrl_sc: RTL and testbench

- Single-clock multi-queue FIFO controller that partitions one external dual-port RAM into 2^NQ_LOG2 independent circular FIFOs.
- Port A of the RAM is the write port; port B is the read port.
- The block owns per-queue write/read pointers and fill counts, and generates RAM addresses and write enables.
- It also provides full/empty flags and error pulses for the queue-facing side.
- It sits between packet/queue producers and consumers and the shared RAM instance.

---
 rtl/vfifo_mq_pkg.sv | 19 +
 rtl/vfifo_queue_state.sv | 44 ++++
 rtl/vfifo_mq_ctrl_sc.sv | 83 ++++++++
 tb/tb_vfifo_mq_ctrl_sc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vfifo_mq_pkg.sv
// vfifo_mq_pkg: shared helpers and default geometry for the multi-queue FIFO controller.
package vfifo_mq_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NQ_LOG2    = 2;
    localparam int QW             = DEF_ADDR_WIDTH - DEF_NQ_LOG2;
    localparam int DEPTH          = 1 << QW;

    typedef logic [QW-1:0] ptr_t;
    typedef logic [QW:0]   cnt_t;

endpackage

// File: rtl/vfifo_queue_state.sv
// vfifo_queue_state: pointers, fill count and registered full/empty flags of one circular queue.
module vfifo_queue_state
    import vfifo_mq_pkg::*;
#(
    parameter  int QDEPTH = DEPTH,
    localparam int QPW    = clog2(QDEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_inc_i,
    input  logic           rd_inc_i,
    output logic [QPW-1:0] wr_ptr_o,
    output logic [QPW-1:0] rd_ptr_o,
    output logic           full_o,
    output logic           empty_o
);
    logic [QPW-1:0] wr_ptr_q, rd_ptr_q;
    logic [QPW:0]   cnt_q, cnt_d;
    logic           full_q, empty_q;

    assign cnt_d = cnt_q + (QPW+1)'(wr_inc_i) - (QPW+1)'(rd_inc_i);

    // Pointers wrap naturally at QDEPTH because it is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_q + QPW'(wr_inc_i);
            rd_ptr_q <= rd_ptr_q + QPW'(rd_inc_i);
            cnt_q    <= cnt_d;
            full_q   <= cnt_d == (QPW+1)'(QDEPTH);
            empty_q  <= cnt_d == '0;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;
endmodule

// File: rtl/vfifo_mq_ctrl_sc.sv
// vfifo_mq_ctrl_sc: splits one dual-port RAM into 2^NQ_LOG2 circular FIFOs;
// port A writes, port B reads with one cycle of RAM output latency.
module vfifo_mq_ctrl_sc
    import vfifo_mq_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 8,
    parameter  int NQ_LOG2    = 2,
    localparam int NQ         = 1 << NQ_LOG2,
    localparam int QPW        = ADDR_WIDTH - NQ_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [NQ_LOG2-1:0]    wr_q,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [NQ_LOG2-1:0]    rd_q,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [NQ-1:0]         full,
    output logic [NQ-1:0]         empty,
    output logic                  wr_err,
    output logic                  rd_err,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    logic [QPW-1:0] wr_ptr [NQ];
    logic [QPW-1:0] rd_ptr [NQ];
    logic [NQ-1:0]  wr_inc, rd_inc;
    logic           wr_acc, rd_acc;
    logic           rd_valid_q, wr_err_q, rd_err_q;
    logic           rd_valid_d, wr_err_d, rd_err_d;

    // Registered flags gate acceptance, so a full queue never passes a write
    // through a same-cycle read and an empty queue never bypasses a write.
    assign wr_acc = wr_en & ~full[wr_q];
    assign rd_acc = rd_en & ~empty[rd_q];

    for (genvar i = 0; i < NQ; i++) begin : g_q
        assign wr_inc[i] = wr_acc && (wr_q == NQ_LOG2'(i));
        assign rd_inc[i] = rd_acc && (rd_q == NQ_LOG2'(i));
        vfifo_queue_state #(.QDEPTH(1 << QPW)) u_state (
            .clk      (clk),
            .rst      (rst),
            .wr_inc_i (wr_inc[i]),
            .rd_inc_i (rd_inc[i]),
            .wr_ptr_o (wr_ptr[i]),
            .rd_ptr_o (rd_ptr[i]),
            .full_o   (full[i]),
            .empty_o  (empty[i])
        );
    end

    assign ram_we_a  = wr_acc;
    assign ram_adr_a = {wr_q, wr_ptr[wr_q]};
    assign ram_d_a   = wr_data;
    assign ram_adr_b = {rd_q, rd_ptr[rd_q]};

    assign rd_valid_d = rd_acc;
    assign wr_err_d   = wr_en & full[wr_q];
    assign rd_err_d   = rd_en & empty[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign wr_err   = wr_err_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = ram_q_b;
endmodule

// File: tb/tb_vfifo_mq_ctrl_sc.sv
// tb_vfifo_mq_ctrl_sc: scenario tasks for the multi-queue FIFO controller with a
// behavioural RAM and a read-data scoreboard (ADDR_WIDTH=4, NQ_LOG2=2, DEPTH=4).
module tb_vfifo_mq_ctrl_sc;
    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [1:0]  wr_q, rd_q;
    logic [31:0] wr_data, rd_data, ram_d_a, ram_q_b;
    logic        rd_valid, wr_err, rd_err, ram_we_a;
    logic [3:0]  full, empty, ram_adr_a, ram_adr_b;

    logic [31:0] mem [16];
    logic [31:0] mdata [4][4];
    int          mcnt [4];
    int          mwr [4];
    int          mrd [4];
    logic [31:0] sb [$];
    logic        exp_v = 1'b0;
    int          total = 0, bad = 0, vcount = 0;

    vfifo_mq_ctrl_sc #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NQ_LOG2(2)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_q(wr_q), .wr_data(wr_data),
        .rd_en(rd_en), .rd_q(rd_q), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .wr_err(wr_err), .rd_err(rd_err),
        .ram_d_a(ram_d_a), .ram_adr_a(ram_adr_a), .ram_we_a(ram_we_a),
        .ram_adr_b(ram_adr_b), .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= mem[ram_adr_b];
    end

    task automatic set_in(input logic we, input logic [1:0] wq, input logic [31:0] wd,
                          input logic re, input logic [1:0] rq);
        wr_en = we; wr_q = wq; wr_data = wd; rd_en = re; rd_q = rq;
    endtask

    // Advance one clock, update the reference model and check read data from the scoreboard.
    task automatic tick();
        logic wa, ra;
        logic [31:0] e;
        wa = wr_en && mcnt[wr_q] != 4;
        ra = rd_en && mcnt[rd_q] != 0;
        @(posedge clk);
        if (rst) begin
            for (int q = 0; q < 4; q++) begin mcnt[q] = 0; mwr[q] = 0; mrd[q] = 0; end
            sb.delete();
            exp_v = 1'b0;
        end else begin
            exp_v = ra;
            if (ra) begin
                sb.push_back(mdata[rd_q][mrd[rd_q]]);
                mrd[rd_q] = (mrd[rd_q] + 1) % 4;
                mcnt[rd_q]--;
            end
            if (wa) begin
                mdata[wr_q][mwr[wr_q]] = wr_data;
                mwr[wr_q] = (mwr[wr_q] + 1) % 4;
                mcnt[wr_q]++;
            end
        end
        @(negedge clk);
        if (rd_valid === 1'b1) vcount++;
        total++;
        if (rd_valid !== exp_v) begin
            bad++;
            $display("FAIL rd_valid: got %b want %b at %0t", rd_valid, exp_v, $time);
        end
        if (exp_v && sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (rd_data !== e) begin
                bad++;
                $display("FAIL rd_data: got %h want %h at %0t", rd_data, e, $time);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (empty !== 4'b1111) begin bad++; $display("FAIL reset_empty: got %b want 1111", empty); end
        total++; if (full !== 4'b0000) begin bad++; $display("FAIL reset_full: got %b want 0000", full); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
        total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 2, 32'(32'hA0 + i), 0, 0);
            #1;
            total++;
            if (ram_we_a !== 1'b1 || ram_adr_a !== 4'(8 + i) || ram_d_a !== 32'(32'hA0 + i)) begin
                bad++;
                $display("FAIL fill_port_a[%0d]: got we=%b adr=%0d d=%h want we=1 adr=%0d d=%h",
                         i, ram_we_a, ram_adr_a, ram_d_a, 8 + i, 32'hA0 + i);
            end
            tick();
            total++;
            if (full[2] !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full[2], i == 3); end
        end
        set_in(1, 2, 32'hEE, 0, 0);
        #1;
        total++; if (ram_we_a !== 1'b0) begin bad++; $display("FAIL fill_reject_we: got %b want 0", ram_we_a); end
        tick();
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL fill_wr_err: got %b want 1", wr_err); end
        set_in(0, 0, 0, 0, 0);
        tick();
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL fill_wr_err_pulse: got %b want 0", wr_err); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 1, 2);
            #1;
            total++; if (ram_adr_b !== 4'(8 + i)) begin bad++; $display("FAIL drain_adr_b[%0d]: got %0d want %0d", i, ram_adr_b, 8 + i); end
            tick();
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d]: got %b want 1", i, rd_valid); end
            total++; if (empty[2] !== (i == 3)) begin bad++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty[2], i == 3); end
        end
        set_in(0, 0, 0, 1, 2);
        tick();
        total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL drain_rd_err: got %b want 1", rd_err); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_reject_valid: got %b want 0", rd_valid); end
        set_in(0, 0, 0, 0, 0);
        tick();
        total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL drain_rd_err_pulse: got %b want 0", rd_err); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 1, 32'(32'hB0 + i), 0, 0);
            #1;
            total++; if (ram_adr_a !== 4'(4 + i % 4)) begin bad++; $display("FAIL wrap_adr_a[%0d]: got %0d want %0d", i, ram_adr_a, 4 + i % 4); end
            tick();
            total++; if (full[1] !== 1'b0 || empty[1] !== 1'b0) begin bad++; $display("FAIL wrap_flags[%0d]: got full=%b empty=%b want 0 0", i, full[1], empty[1]); end
            set_in(0, 0, 0, 1, 1);
            tick();
            total++; if (empty[1] !== 1'b1) begin bad++; $display("FAIL wrap_empty[%0d]: got %b want 1", i, empty[1]); end
        end
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        int v0;
        set_in(1, 3, 32'hC0, 0, 0); tick();
        set_in(1, 3, 32'hC1, 0, 0); tick();
        v0 = vcount;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 3, 32'(32'hC2 + i), 1, 3);
            tick();
            total++; if (full[3] !== 1'b0 || empty[3] !== 1'b0) begin bad++; $display("FAIL b2b_flags[%0d]: got full=%b empty=%b want 0 0", i, full[3], empty[3]); end
        end
        total++; if (vcount - v0 !== 10) begin bad++; $display("FAIL b2b_pulses: got %0d want 10", vcount - v0); end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 32'(32'hD0 + i), 1, 3);
            tick();
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL indep_valid[%0d]: got %b want 1", i, rd_valid); end
        end
        total++; if (empty !== 4'b1110 || full !== 4'b0000) begin bad++; $display("FAIL indep_flags: got empty=%b full=%b want 1110 0000", empty, full); end
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 32'hD2, 0, 0); tick();
        set_in(0, 0, 0, 1, 0); tick();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
        total++; if (empty !== 4'b1111) begin bad++; $display("FAIL mid_empty: got %b want 1111", empty); end
        set_in(1, 0, 32'hE0, 0, 0);
        #1;
        total++; if (ram_we_a !== 1'b1 || ram_adr_a !== 4'd0) begin bad++; $display("FAIL mid_adr_a: got we=%b adr=%0d want we=1 adr=0", ram_we_a, ram_adr_a); end
        tick();
        set_in(0, 0, 0, 1, 0); tick();
        set_in(0, 0, 0, 0, 0); tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drained: got %0d left want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
